// File: rtl/hazard_stall_controller_pkg.sv
// cpu_ctrl_pkg: shared types and widths for the pipeline hazard/stall control slice.
package cpu_ctrl_pkg;
   typedef enum logic [0:0] {RUN, MD_WAIT} state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: pipeline-side hazard inputs and stage enable/bubble outputs.
interface hazard_stall_controller_if;
   import cpu_ctrl_pkg::*;
   logic                   idex_memread;
   logic                   idex_muldiv;
   logic [REG_W-1:0]       idex_regt;
   logic [REG_W-1:0]       ifid_regs;
   logic [REG_W-1:0]       ifid_regt;
   logic                   ifid_uses_rt;
   logic                   branch_taken_i;
   logic                   pc_write;
   logic                   ifid_write;
   logic                   ifid_flush;
   logic                   idex_write;
   logic                   idex_bubble;
   logic                   exmem_bubble;
   logic                   muldiv_start;
   logic                   muldiv_done;
   logic [STALL_CNT_W-1:0] stall_cnt;
   modport master (
      output idex_memread, idex_muldiv, idex_regt, ifid_regs, ifid_regt, ifid_uses_rt, branch_taken_i,
      input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
             muldiv_start, muldiv_done, stall_cnt
   );
   modport slave (
      input  idex_memread, idex_muldiv, idex_regt, ifid_regs, ifid_regt, ifid_uses_rt, branch_taken_i,
      output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
             muldiv_start, muldiv_done, stall_cnt
   );
endinterface

// File: rtl/hazard_stall_controller_lud.sv
// load_use_detector: flags a load in ID/EX whose destination is a source of the IF/ID instruction.
module load_use_detector
   import cpu_ctrl_pkg::*;
(
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_regt,
   input  logic [REG_W-1:0] ifid_regs,
   input  logic [REG_W-1:0] ifid_regt,
   input  logic             ifid_uses_rt,
   output logic             hazard
);
   assign hazard = idex_memread && idex_regt != REG_ZERO &&
                   (idex_regt == ifid_regs || (ifid_uses_rt && idex_regt == ifid_regt));
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: per-cycle PC/IF/ID/ID/EX/EX/MEM sequencing for load-use, branch and mult/div.
module hazard_stall_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = 8
) (
   input logic                     clk_i,
   input logic                     rst_i,
   hazard_stall_controller_if.slave bus
);
   state_t                 r_state;
   logic [7:0]             r_cnt;
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic                   w_hazard, w_detect, w_wait, w_done, w_branch, w_lu, w_md_stall;
   load_use_detector u_lud (
      .idex_memread (bus.idex_memread),
      .idex_regt    (bus.idex_regt),
      .ifid_regs    (bus.ifid_regs),
      .ifid_regt    (bus.ifid_regt),
      .ifid_uses_rt (bus.ifid_uses_rt),
      .hazard       (w_hazard)
   );
   // Priority in RUN: mult/div detect, then taken branch, then load-use.
   assign w_detect   = r_state == RUN && bus.idex_muldiv;
   assign w_branch   = r_state == RUN && !bus.idex_muldiv && bus.branch_taken_i;
   assign w_lu       = r_state == RUN && !bus.idex_muldiv && !bus.branch_taken_i && w_hazard;
   assign w_wait     = r_state == MD_WAIT && r_cnt != 8'd0;
   assign w_done     = r_state == MD_WAIT && r_cnt == 8'd0;
   assign w_md_stall = w_detect || w_wait;
   assign bus.pc_write     = !(w_md_stall || w_lu);
   assign bus.ifid_write   = !(w_md_stall || w_lu);
   assign bus.idex_write   = !w_md_stall;
   assign bus.ifid_flush   = w_branch;
   assign bus.idex_bubble  = w_branch || w_lu;
   assign bus.exmem_bubble = w_md_stall;
   assign bus.muldiv_start = w_detect;
   assign bus.muldiv_done  = w_done;
   assign bus.stall_cnt    = r_stall_cnt;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= RUN;
         r_cnt       <= 8'd0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_detect ? MD_WAIT : w_done ? RUN : r_state;
         r_cnt       <= w_detect ? 8'(MD_CYCLES - 2) : w_wait ? r_cnt - 8'd1 : r_cnt;
         r_stall_cnt <= (!bus.pc_write && !(&r_stall_cnt)) ? r_stall_cnt + 1'b1 : r_stall_cnt;
      end
   end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed + random checks of two controller instances against a cycle-position model.
module tb_hazard_stall_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   logic       mr, md, br, ut;
   logic [4:0] rt, rs, ft;
   hazard_stall_controller_if b8 ();
   hazard_stall_controller_if b2 ();
   assign b8.idex_memread = mr;   assign b2.idex_memread = mr;
   assign b8.idex_muldiv = md;    assign b2.idex_muldiv = md;
   assign b8.branch_taken_i = br; assign b2.branch_taken_i = br;
   assign b8.ifid_uses_rt = ut;   assign b2.ifid_uses_rt = ut;
   assign b8.idex_regt = rt;      assign b2.idex_regt = rt;
   assign b8.ifid_regs = rs;      assign b2.ifid_regs = rs;
   assign b8.ifid_regt = ft;      assign b2.ifid_regt = ft;
   hazard_stall_controller #(.MD_CYCLES(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(b8));
   hazard_stall_controller #(.MD_CYCLES(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(b2));
   int n_cmp = 0;
   int n_bad = 0;
   int pos8, pos2, sc8, sc2;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // pos = 0 when no mult/div is in flight, else the 1-based cycle number within the sequence.
   function automatic logic [7:0] model(input int pos, input int mdc);
      logic pc, ifw, fl, idw, bub, exb, st, dn, haz;
      pc = 1; ifw = 1; fl = 0; idw = 1; bub = 0; exb = 0; st = 0; dn = 0;
      haz = mr && rt != 0 && (rt == rs || (ut && rt == ft));
      if (pos == 0 && md) begin
         pc = 0; ifw = 0; idw = 0; exb = 1; st = 1;
      end else if (pos == 0 && br) begin
         fl = 1; bub = 1;
      end else if (pos == 0 && haz) begin
         pc = 0; ifw = 0; bub = 1;
      end else if (pos > 0 && pos < mdc) begin
         pc = 0; ifw = 0; idw = 0; exb = 1;
      end else if (pos == mdc) begin
         dn = 1;
      end
      return {pc, ifw, fl, idw, bub, exb, st, dn};
   endfunction
   function automatic int next_pos(input int pos, input int mdc);
      return pos == 0 ? (md ? 2 : 0) : pos == mdc ? 0 : pos + 1;
   endfunction
   task automatic step(input bit check);
      logic [7:0] e8, e2;
      @(negedge clk);
      e8 = model(pos8, 8);
      e2 = model(pos2, 2);
      if (check) begin
         chk("out_md8", {b8.pc_write, b8.ifid_write, b8.ifid_flush, b8.idex_write, b8.idex_bubble,
                         b8.exmem_bubble, b8.muldiv_start, b8.muldiv_done}, e8);
         chk("out_md2", {b2.pc_write, b2.ifid_write, b2.ifid_flush, b2.idex_write, b2.idex_bubble,
                         b2.exmem_bubble, b2.muldiv_start, b2.muldiv_done}, e2);
         chk("stall_cnt_md8", b8.stall_cnt, sc8);
         chk("stall_cnt_md2", b2.stall_cnt, sc2);
      end
      @(posedge clk);
      if (!rst) begin
         if (!e8[7]) sc8 = sc8 < 65535 ? sc8 + 1 : 65535;
         if (!e2[7]) sc2 = sc2 < 65535 ? sc2 + 1 : 65535;
         pos8 = next_pos(pos8, 8);
         pos2 = next_pos(pos2, 2);
      end
      #1;
   endtask
   task automatic drive(input logic a, b, c, d, input logic [4:0] t, s, f);
      mr = a; md = b; br = c; ut = d; rt = t; rs = s; ft = f;
   endtask
   initial begin
      int s0;
      rst = 1; pos8 = 0; pos2 = 0; sc8 = 0; sc2 = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      step(1);
      drive(1, 0, 0, 0, 8, 8, 0);
      step(1);
      rst = 0;
      step(1);
      chk("lu_one_stall", b8.stall_cnt, 1);
      drive(0, 0, 0, 0, 8, 8, 0); step(1);
      drive(1, 0, 0, 0, 0, 0, 0); step(1);
      drive(1, 0, 0, 0, 9, 1, 9); step(1);
      drive(1, 0, 0, 1, 9, 1, 9); step(1);
      drive(0, 0, 1, 0, 0, 0, 0); step(1);
      drive(1, 0, 1, 0, 8, 8, 0); step(1);
      drive(0, 0, 0, 0, 0, 0, 0); step(1);
      chk("branch_no_stall", b8.stall_cnt, 2);
      s0 = sc8;
      drive(0, 1, 0, 0, 0, 0, 0); step(1);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(1);
      chk("md8_stall_cycles", b8.stall_cnt - s0, 7);
      chk("md8_back_in_run", b8.pc_write, 1);
      drive(0, 1, 0, 0, 0, 0, 0); step(1);
      drive(0, 0, 0, 0, 0, 0, 0); step(1);
      step(1);
      #2 rst = 1;
      pos8 = 0; pos2 = 0; sc8 = 0; sc2 = 0;
      step(1);
      chk("rst_no_done", b8.muldiv_done, 0);
      rst = 0;
      for (int i = 0; i < 10; i++) step(1);
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         step(1);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1);
      drive(1, 0, 0, 0, 8, 8, 0);
      for (int i = 0; i < 65540; i++) step(i % 4096 == 0);
      step(1);
      chk("saturated", b8.stall_cnt, 16'hFFFF);
      chk("saturated_md2", b2.stall_cnt, 16'hFFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
